data_mem_lsu: RTL and testbench

//   Load/store initiator for the 32x8 data memory (sync write on Clk when enabled, async read).

---
 rtl/data_mem_lsu_if.sv | 35 +++
 rtl/data_mem_lsu.sv | 94 +++++++++
 tb/tb_data_mem_lsu.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: CPU command, byte stream and data memory pins of the load/store unit.
// The master modport is the CPU/memory side; the slave modport is the LSU itself.
interface data_mem_lsu_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_write, req_addr, req_len, wr_data, wr_valid, rd_ready, mem_rdata,
        input  req_ready, wr_ready, rd_data, rd_valid, mem_addr, mem_wdata, mem_en, busy, done, err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid, rd_ready, mem_rdata,
        output req_ready, wr_ready, rd_data, rd_valid, mem_addr, mem_wdata, mem_en, busy, done, err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: burst load/store initiator for a 32x8 sync-write/async-read data memory.
// Define DATA_MEM_LSU_WRAP_ERR_EN to reject bursts that would wrap past the top address.
module data_mem_lsu #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    data_mem_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_err;
    logic              w_accept;
    logic              w_reject;
    logic              w_wr_hs;
    logic              w_rd_hs;
    logic              w_last;

    assign bus.req_ready = !i_rst && r_state == IDLE;
    assign bus.wr_ready  = !i_rst && r_state == WRITE;
    assign bus.mem_en    = bus.wr_ready && bus.wr_valid;
    assign bus.mem_wdata = bus.wr_data;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.busy      = r_state != IDLE;
    assign bus.done      = r_state == DONE;
    assign bus.err       = r_err;

    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_wr_hs  = bus.mem_en;
    assign w_rd_hs  = r_state == READ && r_rd_valid && bus.rd_ready;
    assign w_last   = r_count == '0;

`ifdef DATA_MEM_LSU_WRAP_ERR_EN
    logic [ADDR_W:0] w_end;
    assign w_end    = {1'b0, bus.req_addr} + (ADDR_W+1)'(bus.req_len);
    assign w_reject = w_end[ADDR_W];
`else
    assign w_reject = 1'b0;
`endif

    // A read handshake looks ahead one address so the next byte lands on the same edge
    assign bus.mem_addr = w_rd_hs ? r_addr + ADDR_W'(1) : r_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_accept && !w_reject) ? (bus.req_write ? WRITE : READ) : IDLE;
            WRITE:   w_next = (w_wr_hs && w_last) ? DONE : WRITE;
            READ:    w_next = (w_rd_hs && w_last) ? DONE : READ;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_accept && w_reject;
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_count <= bus.req_len;
            end
            if (w_wr_hs && !w_last) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_count <= r_count - LEN_W'(1);
            end
            if (r_state == READ && !r_rd_valid) begin
                r_rd_data  <= bus.mem_rdata;
                r_rd_valid <= 1'b1;
            end else if (w_rd_hs && w_last) begin
                r_rd_valid <= 1'b0;
            end else if (w_rd_hs) begin
                r_addr    <= r_addr + ADDR_W'(1);
                r_count   <= r_count - LEN_W'(1);
                r_rd_data <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: randomized and directed checks of data_mem_lsu against an array model of memory.
module tb_data_mem_lsu;
    logic clk;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    data_mem_lsu_if bus ();
    data_mem_lsu dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];
    logic       poke_en;
    logic [4:0] poke_addr;
    logic [7:0] poke_data;
    logic [4:0] wa_q [$];
    logic [7:0] wd_q [$];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
        end
        if (poke_en) mem[poke_addr] <= poke_data;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d; ref_mem[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic send_req(input logic wr, input logic [4:0] a, input logic [2:0] l, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_len = l;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (bus.req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic stream_store(input logic [7:0] d [8], input int n, input int stall_pct, output bit ok);
        ok = 1'b1;
        for (int b = 0; b < n && ok; b++) begin
            if (int'($urandom_range(99)) < stall_pct) begin
                bus.wr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            bus.wr_valid = 1'b1; bus.wr_data = d[b];
            ok = 1'b0;
            for (int i = 0; i < 30; i++) begin
                #1;
                if (bus.wr_ready) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic recv_load(input int n, input int stall_pct, output logic [7:0] q [8], output int got);
        got = 0;
        for (int i = 0; i < 200 && got < n; i++) begin
            bus.rd_ready = int'($urandom_range(99)) >= stall_pct;
            #1;
            if (bus.rd_valid && bus.rd_ready) begin q[got] = bus.rd_data; got++; end
            @(negedge clk);
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); else passed++;
        checks++; if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en got=%b exp=0", bus.mem_en); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else passed++;
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready_gated got=%b exp=0", bus.req_ready); else passed++;
        checks++; if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL release_req_ready got=%b exp=1", bus.req_ready); else passed++;
    endtask

    task automatic test_store_single;
        int  base = wa_q.size();
        bit  ok;
        send_req(1'b1, 5'd5, 3'd0, ok);
        checks++; if (ok !== 1'b1) $display("FAIL single_accept got=%b exp=1", ok); else passed++;
        bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
        #1;
        checks++; if ({bus.mem_en, bus.mem_addr, bus.mem_wdata} !== {1'b1, 5'd5, 8'hA5})
            $display("FAIL single_mem_pins got=%b/%0d/%h exp=1/5/a5", bus.mem_en, bus.mem_addr, bus.mem_wdata); else passed++;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        ref_mem[5] = 8'hA5;
        #1;
        checks++; if (bus.done !== 1'b1) $display("FAIL single_done got=%b exp=1", bus.done); else passed++;
        repeat (2) @(negedge clk);
        checks++; if (wa_q.size() - base !== 1) $display("FAIL single_en_cycles got=%0d exp=1", wa_q.size() - base); else passed++;
        checks++; if (mem[5] !== 8'hA5) $display("FAIL single_mem5 got=%h exp=a5", mem[5]); else passed++;
    endtask

    task automatic test_store_wrap;
        int         base = wa_q.size();
        bit         ok;
        logic [7:0] d [8];
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        send_req(1'b1, 5'd30, 3'd3, ok);
        checks++; if (ok !== 1'b1) $display("FAIL wrap_accept got=%b exp=1", ok); else passed++;
`ifdef DATA_MEM_LSU_WRAP_ERR_EN
        #1;
        checks++; if ({bus.err, bus.busy} !== 2'b10) $display("FAIL wrap_err_pulse got err/busy=%b%b exp=10", bus.err, bus.busy); else passed++;
        bus.wr_valid = 1'b1; bus.wr_data = 8'h11;
        @(negedge clk);
        #1;
        checks++; if ({bus.err, bus.done} !== 2'b00) $display("FAIL wrap_err_one_cycle got err/done=%b%b exp=00", bus.err, bus.done); else passed++;
        repeat (4) @(negedge clk);
        bus.wr_valid = 1'b0;
        checks++; if (wa_q.size() - base !== 0) $display("FAIL wrap_no_writes got=%0d exp=0", wa_q.size() - base); else passed++;
        checks++; if (mem[30] !== ref_mem[30]) $display("FAIL wrap_mem30 got=%h exp=%h", mem[30], ref_mem[30]); else passed++;
`else
        stream_store(d, 4, 0, ok);
        checks++; if (ok !== 1'b1) $display("FAIL wrap_stream got=%b exp=1", ok); else passed++;
        wait_done(ok);
        checks++; if (ok !== 1'b1) $display("FAIL wrap_done got=%b exp=1", ok); else passed++;
        checks++; if (wa_q.size() - base !== 4) $display("FAIL wrap_en_cycles got=%0d exp=4", wa_q.size() - base); else passed++;
        for (int b = 0; b < 4; b++) begin
            logic [4:0] ea = 5'd30 + 5'(b);
            ref_mem[ea] = d[b];
            checks++; if ({wa_q[base+b], wd_q[base+b]} !== {ea, d[b]})
                $display("FAIL wrap_beat%0d got=%0d/%h exp=%0d/%h", b, wa_q[base+b], wd_q[base+b], ea, d[b]); else passed++;
        end
`endif
    endtask

    task automatic test_load_stall;
        int         base = wa_q.size();
        int         got = 0, stall = 0, held_bad = 0;
        bit         ok;
        logic [7:0] q [8];
        poke(5'd4, 8'h10); poke(5'd5, 8'h20); poke(5'd6, 8'h30);
        send_req(1'b0, 5'd4, 3'd2, ok);
        checks++; if (ok !== 1'b1) $display("FAIL load_accept got=%b exp=1", ok); else passed++;
        for (int i = 0; i < 40 && got < 3; i++) begin
            bus.rd_ready = !(got == 1 && stall < 3);
            #1;
            if (bus.rd_valid) begin
                if (!bus.rd_ready) begin
                    stall++;
                    if (bus.rd_data !== 8'h20) held_bad++;
                end else begin
                    q[got] = bus.rd_data;
                    got++;
                end
            end
            @(negedge clk);
        end
        bus.rd_ready = 1'b0;
        #1;
        checks++; if ({bus.done, bus.rd_valid} !== 2'b10) $display("FAIL load_done got done/rd_valid=%b%b exp=10", bus.done, bus.rd_valid); else passed++;
        checks++; if ({q[0], q[1], q[2]} !== 24'h102030) $display("FAIL load_data got=%h%h%h exp=102030", q[0], q[1], q[2]); else passed++;
        checks++; if (held_bad !== 0 || stall !== 3) $display("FAIL load_hold got bad=%0d stalls=%0d exp=0/3", held_bad, stall); else passed++;
        checks++; if (wa_q.size() - base !== 0) $display("FAIL load_no_mem_en got=%0d exp=0", wa_q.size() - base); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst;
        int         base;
        bit         ok;
        logic [7:0] d [8];
        d = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00};
        poke(5'd12, 8'hEE); poke(5'd13, 8'hEF);
        base = wa_q.size();
        send_req(1'b1, 5'd10, 3'd3, ok);
        stream_store(d, 2, 0, ok);
        bus.wr_valid = 1'b1; bus.wr_data = 8'h63; rst = 1'b1;
        #1;
        checks++; if ({bus.mem_en, bus.wr_ready} !== 2'b00) $display("FAIL rstmid_gating got en/ready=%b%b exp=00", bus.mem_en, bus.wr_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.req_ready} !== 2'b01) $display("FAIL rstmid_idle got busy/req_ready=%b%b exp=01", bus.busy, bus.req_ready); else passed++;
        bus.wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        ref_mem[10] = 8'h61; ref_mem[11] = 8'h62;
        checks++; if (wa_q.size() - base !== 2) $display("FAIL rstmid_writes got=%0d exp=2", wa_q.size() - base); else passed++;
        for (int a = 10; a < 14; a++) begin
            checks++; if (mem[a] !== ref_mem[a]) $display("FAIL rstmid_mem%0d got=%h exp=%h", a, mem[a], ref_mem[a]); else passed++;
        end
    endtask

    task automatic test_busy_ignore;
        int         got = 0, bad = 0;
        bit         ok;
        logic [7:0] q [8];
        logic [7:0] q2 [8];
        poke(5'd20, 8'h5C);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 5'd4; bus.req_len = 3'd2;
        #1;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL busy_first_ready got=%b exp=1", bus.req_ready); else passed++;
        @(negedge clk);
        bus.req_addr = 5'd20; bus.req_len = 3'd0;
        for (int i = 0; i < 40 && got < 3; i++) begin
            bus.rd_ready = 1'b1;
            #1;
            if (bus.req_ready) bad++;
            if (bus.rd_valid) begin q[got] = bus.rd_data; got++; end
            @(negedge clk);
        end
        bus.rd_ready = 1'b0;
        #1;
        checks++; if ({bus.done, bus.req_ready} !== 2'b10) $display("FAIL busy_done_state got done/req_ready=%b%b exp=10", bus.done, bus.req_ready); else passed++;
        checks++; if (bad !== 0) $display("FAIL busy_req_ready_while_busy got=%0d exp=0", bad); else passed++;
        checks++; if ({q[0], q[1], q[2]} !== {ref_mem[4], ref_mem[5], ref_mem[6]})
            $display("FAIL busy_first_data got=%h%h%h exp=%h%h%h", q[0], q[1], q[2], ref_mem[4], ref_mem[5], ref_mem[6]); else passed++;
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL busy_second_ready got=%b exp=1", bus.req_ready); else passed++;
        @(negedge clk);
        bus.req_valid = 1'b0;
        recv_load(1, 0, q2, got);
        checks++; if (got !== 1 || q2[0] !== ref_mem[20]) $display("FAIL busy_second_data got=%0d/%h exp=1/%h", got, q2[0], ref_mem[20]); else passed++;
        wait_done(ok);
    endtask

    task automatic test_random;
        bit         ok;
        int         got, bad;
        logic       wr;
        logic [4:0] a;
        logic [2:0] l;
        logic [7:0] d [8];
        logic [7:0] q [8];
        for (int i = 0; i < 32; i++) poke(5'(i), 8'($urandom));
        for (int it = 0; it < 25; it++) begin
            wr = 1'($urandom_range(1));
            a  = 5'($urandom_range(31));
            l  = 3'($urandom_range(7));
`ifdef DATA_MEM_LSU_WRAP_ERR_EN
            if (int'(a) + int'(l) > 31) l = 3'(31 - int'(a));
`endif
            send_req(wr, a, l, ok);
            bad = ok ? 0 : 1;
            if (wr) begin
                for (int b = 0; b < 8; b++) d[b] = 8'($urandom);
                stream_store(d, int'(l) + 1, 30, ok);
                if (!ok) bad++;
                for (int b = 0; b <= int'(l); b++) ref_mem[a + 5'(b)] = d[b];
            end else begin
                recv_load(int'(l) + 1, 30, q, got);
                if (got != int'(l) + 1) bad++;
                for (int b = 0; b < got; b++) if (q[b] !== ref_mem[a + 5'(b)]) bad++;
            end
            checks++; if (bad !== 0) $display("FAIL random_burst%0d wr=%b addr=%0d len=%0d errors=%0d exp=0", it, wr, a, l, bad); else passed++;
            wait_done(ok);
            checks++; if (ok !== 1'b1) $display("FAIL random_done%0d got=%b exp=1", it, ok); else passed++;
        end
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) $display("FAIL random_mem%0d got=%h exp=%h", i, mem[i], ref_mem[i]); else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        test_reset;
        test_store_single;
        test_store_wrap;
        test_load_stall;
        test_reset_mid_burst;
        test_busy_ignore;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
